// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioner: default sizing, channel
// assignments on the pad ring and the default debounce mask.
package input_cond_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Channel positions of the physical inputs.
  localparam int CH_FORK  = 0;
  localparam int CH_CRANK = 1;
  localparam int CH_TRIP  = 2;
  localparam int CH_MODE  = 3;

  // Buttons (trip, mode) bounce and are debounced; the sensors are not.
  // Held at the maximum channel width so any CHANNELS can slice it.
  localparam logic [15:0] DEF_DEBOUNCE_MASK = 16'h000C;

endpackage

// File: rtl/input_conditioner_if.sv
// Bus between the pad ring (master) and the input conditioner (slave).
// nIn is raw, active-low and asynchronous; the rest is in the core domain.
interface input_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] nIn;
  logic [CHANNELS-1:0] Active;
  logic [CHANNELS-1:0] Press;
  logic [CHANNELS-1:0] Release;

  modport master (output nIn, input Active, input Press, input Release);
  modport slave  (input nIn, output Active, output Press, output Release);
endinterface

// File: rtl/input_cond_channel.sv
// One conditioner channel: synchroniser chain, optional debounce counter,
// and registered press/release pulses aligned with the Active change.
module input_cond_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit DEBOUNCE        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic n_in,
  output logic active,
  output logic press,
  output logic release_pulse
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;
  logic                   active_q;
  logic                   active_d;
  logic                   press_q;
  logic                   press_d;
  logic                   release_q;
  logic                   release_d;

  // Shift the raw pad level into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], n_in};
  end

  // Chain resets to the inactive (high) level so reset exit is pulse-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = ~sync_q[SYNC_STAGES-1];

  if (DEBOUNCE) begin : g_debounce
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle agreeing with Active restarts the stability count.
    always_comb begin
      cnt_d    = '0;
      active_d = active_q;
      if (s != active_q) begin
        if (cnt_q == CNT_LAST) begin
          active_d = s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Stability counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_pass
    // Pass-through: Active follows the synchronised level every cycle.
    always_comb begin
      active_d = s;
    end
  end

  // Pulses are computed from the next Active so they appear with it.
  always_comb begin
    press_d   = active_d & ~active_q;
    release_d = ~active_d & active_q;
  end

  // Output registers for level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign active        = active_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for active-low asynchronous pad inputs.
// Define INPUT_COND_DEBOUNCE_EN to enable debouncing on channels selected
// by DEBOUNCE_MASK; without it every channel is pass-through.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int                  CHANNELS        = DEF_CHANNELS,
  parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [CHANNELS-1:0] DEBOUNCE_MASK   = DEF_DEBOUNCE_MASK[CHANNELS-1:0]
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input_conditioner_if.slave   bus
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be in 1..16");
  end

`ifdef INPUT_COND_DEBOUNCE_EN
  localparam logic [CHANNELS-1:0] EFF_MASK = DEBOUNCE_MASK;
`else
  // Mask is ignored: all channels pass through, no counters exist.
  localparam logic [CHANNELS-1:0] EFF_MASK = DEBOUNCE_MASK & {CHANNELS{1'b0}};
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEBOUNCE        (EFF_MASK[gi])
    ) u_channel (
      .clk           (Clock),
      .rst_n         (nReset),
      .n_in          (bus.nIn[gi]),
      .active        (bus.Active[gi]),
      .press         (bus.Press[gi]),
      .release_pulse (bus.Release[gi])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, mask 4'b1100. Expectations follow the macro setting.
module tb_input_conditioner;
  import input_cond_pkg::*;

`ifdef INPUT_COND_DEBOUNCE_EN
  localparam logic [3:0] EFF_MASK = 4'b1100;
`else
  localparam logic [3:0] EFF_MASK = 4'b0000;
`endif
  localparam int LAT_PT = 2;          // SYNC_STAGES
  localparam int LAT_DB = 2 + 8 - 1;  // SYNC_STAGES + DEBOUNCE_CYCLES - 1
  localparam int DB_MIN = 8;

  logic Clock;
  logic nReset;
  int   total = 0;
  int   bad   = 0;

  input_conditioner_if #(.CHANNELS(4)) bus ();

  input_conditioner #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .DEBOUNCE_MASK   (4'b1100)
  ) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int lat(input int i);
    return EFF_MASK[i] ? LAT_DB : LAT_PT;
  endfunction

  task automatic drain();
    bus.nIn = 4'hF;
    repeat (30) tick();
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    logic [3:0] ep;
    nReset  = 1'b0;
    bus.nIn = 4'h0;
    repeat (3) tick();
    total++;
    if (bus.Active !== 4'b0 || bus.Press !== 4'b0 || bus.Release !== 4'b0) begin
      bad++;
      $display("FAIL reset_hold A=%b P=%b R=%b want all 0000", bus.Active, bus.Press, bus.Release);
    end
    nReset = 1'b1;
    for (int n = 0; n < 13; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        ea[i] = (n >= lat(i));
        ep[i] = (n == lat(i));
      end
      total++;
      if (bus.Active !== ea || bus.Press !== ep || bus.Release !== 4'b0) begin
        bad++;
        $display("FAIL reset_exit n=%0d A=%b P=%b R=%b want A=%b P=%b R=0000",
                 n, bus.Active, bus.Press, bus.Release, ea, ep);
      end
    end
    $display("test_reset done");
    drain();
  endtask

  task automatic test_pass_through();
    logic [3:0] ea;
    logic [3:0] ep;
    logic [3:0] er;
    bus.nIn = 4'hF;
    bus.nIn[CH_FORK] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (n == 0) bus.nIn = 4'hF;
      ea = 4'b0; ep = 4'b0; er = 4'b0;
      ea[CH_FORK] = (n == LAT_PT);
      ep[CH_FORK] = (n == LAT_PT);
      er[CH_FORK] = (n == LAT_PT + 1);
      total++;
      if (bus.Active !== ea || bus.Press !== ep || bus.Release !== er) begin
        bad++;
        $display("FAIL pass_through n=%0d A=%b P=%b R=%b want A=%b P=%b R=%b",
                 n, bus.Active, bus.Press, bus.Release, ea, ep, er);
      end
    end
    $display("test_pass_through done");
    drain();
  endtask

  // Low pulses of several widths on the trip button.
  task automatic test_debounce();
    int         widths [4];
    int         w;
    int         l;
    logic       seen;
    logic [3:0] ea;
    logic [3:0] ep;
    logic [3:0] er;
    widths = '{2, 7, 8, 20};
    for (int t = 0; t < 4; t++) begin
      w = widths[t];
      l = lat(CH_TRIP);
      seen = !(EFF_MASK[CH_TRIP] && w < DB_MIN);
      bus.nIn = 4'hF;
      bus.nIn[CH_TRIP] = 1'b0;
      for (int n = 0; n < w + 12; n++) begin
        tick();
        if (n == w - 1) bus.nIn = 4'hF;
        ea = 4'b0; ep = 4'b0; er = 4'b0;
        ea[CH_TRIP] = seen && (n >= l) && (n < w + l);
        ep[CH_TRIP] = seen && (n == l);
        er[CH_TRIP] = seen && (n == w + l);
        total++;
        if (bus.Active !== ea || bus.Press !== ep || bus.Release !== er) begin
          bad++;
          $display("FAIL debounce_w%0d n=%0d A=%b P=%b R=%b want A=%b P=%b R=%b",
                   w, n, bus.Active, bus.Press, bus.Release, ea, ep, er);
        end
      end
      $display("test_debounce width=%0d done", w);
      drain();
    end
  endtask

  task automatic test_simultaneous();
    int         w;
    logic [3:0] ea;
    logic [3:0] ep;
    logic [3:0] er;
    w = 15;
    bus.nIn = 4'hF;
    bus.nIn[CH_CRANK] = 1'b0;
    bus.nIn[CH_MODE]  = 1'b0;
    for (int n = 0; n < w + 12; n++) begin
      tick();
      if (n == w - 1) bus.nIn = 4'hF;
      ea = 4'b0; ep = 4'b0; er = 4'b0;
      for (int i = CH_CRANK; i <= CH_MODE; i += 2) begin
        ea[i] = (n >= lat(i)) && (n < w + lat(i));
        ep[i] = (n == lat(i));
        er[i] = (n == w + lat(i));
      end
      total++;
      if (bus.Active !== ea || bus.Press !== ep || bus.Release !== er) begin
        bad++;
        $display("FAIL simultaneous n=%0d A=%b P=%b R=%b want A=%b P=%b R=%b",
                 n, bus.Active, bus.Press, bus.Release, ea, ep, er);
      end
      total++;
      if ((bus.Press & bus.Release) !== 4'b0) begin
        bad++;
        $display("FAIL pulse_exclusive n=%0d P=%b R=%b want no overlap", n, bus.Press, bus.Release);
      end
    end
    $display("test_simultaneous done");
    drain();
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] ea;
    logic [3:0] ep;
    bus.nIn = 4'hF;
    bus.nIn[CH_MODE] = 1'b0;
    repeat (5) tick();
    nReset = 1'b0;
    #2;
    total++;
    if (bus.Active !== 4'b0 || bus.Press !== 4'b0 || bus.Release !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_count A=%b P=%b R=%b want all 0000", bus.Active, bus.Press, bus.Release);
    end
    nReset = 1'b1;
    for (int n = 0; n < 13; n++) begin
      tick();
      ea = 4'b0; ep = 4'b0;
      ea[CH_MODE] = (n >= lat(CH_MODE));
      ep[CH_MODE] = (n == lat(CH_MODE));
      total++;
      if (bus.Active !== ea || bus.Press !== ep || bus.Release !== 4'b0) begin
        bad++;
        $display("FAIL reset_restart n=%0d A=%b P=%b R=%b want A=%b P=%b R=0000",
                 n, bus.Active, bus.Press, bus.Release, ea, ep);
      end
    end
    $display("test_reset_mid_count done");
    drain();
    total++;
    if (bus.Active !== 4'b0) begin
      bad++;
      $display("FAIL final_idle A=%b want 0000", bus.Active);
    end
  endtask

  initial begin
    nReset  = 1'b0;
    bus.nIn = 4'hF;
    test_reset();
    test_pass_through();
    test_debounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
